// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store unit, optional misaligned-access trap via LSU_MISALIGN_TRAP_EN
module lsu_ctrl (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        ex_vld,
    output logic        ex_rdy,
    input  logic [31:0] ex_out,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [1:0]  ex_size,
    input  logic        ex_lsign,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_wen,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvld,
    input  logic [31:0] mem_rdata,
    output logic [31:0] lsu_out,
    output logic        lsu_out_vld,
    output logic        lsu_ready,
    output logic [31:0] lsu_mem_rdata,
    output logic        lsu_mem_rvld,
    output logic [3:0]  lsu_rstrb,
    output logic [4:0]  lsu_rd,
    output logic        lsu_rd_wen,
    output logic        lsu_lsign,
    output logic        lsu_misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic        cur_load;

    logic        accept;
    logic        op_load;
    logic        op_store;
    logic        size_byte;
    logic        size_half;
    logic        size_word;
    logic        misalign_c;
    logic        mem_op;
    logic [31:0] addr_eff;
    logic [3:0]  lane_c;
    logic [31:0] wdata_c;
    logic [3:0]  rstrb_c;

    assign ex_rdy = (state == S_IDLE);
    assign accept = ex_vld & ex_rdy;

    // Decode the offered instruction: access kind, lanes, replicated store data.
    // A load flag wins if execute ever raises both load and store.
    always_comb begin
        op_load   = ex_load;
        op_store  = ex_store & ~ex_load;
        size_byte = (ex_size == 2'd0);
        size_half = (ex_size == 2'd1);
        size_word = ex_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
        misalign_c = (op_load | op_store) &
                     ((size_half & ex_out[0]) | (size_word & (ex_out[1:0] != 2'b00)));
        addr_eff   = ex_out;
`else
        misalign_c = 1'b0;
        addr_eff   = ex_out;
        if (size_half) begin
            addr_eff[0] = 1'b0;
        end else if (size_word) begin
            addr_eff[1:0] = 2'b00;
        end
`endif

        mem_op = (op_load | op_store) & ~misalign_c;

        lane_c  = 4'b1111;
        wdata_c = ex_sdata;
        if (size_byte) begin
            lane_c  = 4'b0001 << addr_eff[1:0];
            wdata_c = {4{ex_sdata[7:0]}};
        end else if (size_half) begin
            lane_c  = 4'b0011 << {addr_eff[1], 1'b0};
            wdata_c = {2{ex_sdata[15:0]}};
        end

        rstrb_c = (op_load & ~size_word) ? lane_c : 4'b0000;
    end

    // Sequencer: IDLE accepts, REQ holds the request until grant, WAIT takes read data, DONE presents one result.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state        <= S_IDLE;
            cur_load     <= 1'b0;
            mem_req      <= 1'b0;
            lsu_ready    <= 1'b0;
            lsu_out_vld  <= 1'b0;
            lsu_mem_rvld <= 1'b0;
            lsu_misalign <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_load <= op_load;
                        if (mem_op) begin
                            state   <= S_REQ;
                            mem_req <= 1'b1;
                        end else begin
                            state        <= S_DONE;
                            lsu_ready    <= 1'b1;
                            lsu_out_vld  <= 1'b1;
                            lsu_mem_rvld <= 1'b0;
                            lsu_misalign <= misalign_c;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (cur_load) begin
                            state <= S_WAIT;
                        end else begin
                            state        <= S_DONE;
                            lsu_ready    <= 1'b1;
                            lsu_out_vld  <= 1'b1;
                            lsu_mem_rvld <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvld) begin
                        state        <= S_DONE;
                        lsu_ready    <= 1'b1;
                        lsu_out_vld  <= 1'b1;
                        lsu_mem_rvld <= 1'b1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    lsu_ready    <= 1'b0;
                    lsu_out_vld  <= 1'b0;
                    lsu_mem_rvld <= 1'b0;
                    lsu_misalign <= 1'b0;
                end
            endcase
        end
    end

    // Per-instruction fields are captured at acceptance and held steady through REQ/WAIT/DONE.
    // Stores and trapped accesses never write the register file.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wstrb  <= 4'd0;
            lsu_out    <= 32'd0;
            lsu_rstrb  <= 4'd0;
            lsu_rd     <= 5'd0;
            lsu_rd_wen <= 1'b0;
            lsu_lsign  <= 1'b0;
        end else if (accept) begin
            mem_we     <= op_store;
            mem_addr   <= {addr_eff[31:2], 2'b00};
            mem_wdata  <= op_store ? wdata_c : 32'd0;
            mem_wstrb  <= op_store ? lane_c : 4'd0;
            lsu_out    <= ex_out;
            lsu_rstrb  <= rstrb_c;
            lsu_rd     <= ex_rd;
            lsu_rd_wen <= ex_rd_wen & ~op_store & ~misalign_c;
            lsu_lsign  <= ex_lsign;
        end
    end

    // Load data is sampled only while waiting for it; stray responses elsewhere are dropped.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            lsu_mem_rdata <= 32'd0;
        end else if ((state == S_WAIT) && mem_rvld) begin
            lsu_mem_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
`timescale 1ns/1ps
module tb_lsu_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        ex_vld;
    logic        ex_rdy;
    logic [31:0] ex_out;
    logic        ex_load;
    logic        ex_store;
    logic [1:0]  ex_size;
    logic        ex_lsign;
    logic [31:0] ex_sdata;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvld;
    logic [31:0] mem_rdata;
    logic [31:0] lsu_out;
    logic        lsu_out_vld;
    logic        lsu_ready;
    logic [31:0] lsu_mem_rdata;
    logic        lsu_mem_rvld;
    logic [3:0]  lsu_rstrb;
    logic [4:0]  lsu_rd;
    logic        lsu_rd_wen;
    logic        lsu_lsign;
    logic        lsu_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    lsu_ctrl dut (
        .CLK(CLK), .RSTN(RSTN),
        .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_out(ex_out), .ex_load(ex_load),
        .ex_store(ex_store), .ex_size(ex_size), .ex_lsign(ex_lsign),
        .ex_sdata(ex_sdata), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
        .lsu_out(lsu_out), .lsu_out_vld(lsu_out_vld), .lsu_ready(lsu_ready),
        .lsu_mem_rdata(lsu_mem_rdata), .lsu_mem_rvld(lsu_mem_rvld),
        .lsu_rstrb(lsu_rstrb), .lsu_rd(lsu_rd), .lsu_rd_wen(lsu_rd_wen),
        .lsu_lsign(lsu_lsign), .lsu_misalign(lsu_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction at a negedge; it transfers on the following posedge.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
        ex_load = ld; ex_store = st; ex_size = sz; ex_lsign = sg;
        ex_out = a; ex_sdata = sd; ex_rd = rd; ex_rd_wen = we;
        ex_vld = 1'b1;
        check("ex_rdy_before_issue", {31'd0, ex_rdy}, 32'd1);
        @(negedge CLK);
        ex_vld = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0; ex_vld = 1'b0; ex_out = '0; ex_load = 1'b0; ex_store = 1'b0;
        ex_size = 2'd0; ex_lsign = 1'b0; ex_sdata = '0; ex_rd = '0; ex_rd_wen = 1'b0;
        mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge CLK);
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        check("rst_lsu_out",   lsu_out,            32'd0);
        RSTN = 1'b1;
        @(negedge CLK);
        check("rst_ex_rdy",    {31'd0, ex_rdy},    32'd1);

        // ADD: result one cycle after acceptance
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
        check("add_ready",     {31'd0, lsu_ready},    32'd1);
        check("add_out_vld",   {31'd0, lsu_out_vld},  32'd1);
        check("add_out",       lsu_out,               32'h0000_1234);
        check("add_rd",        {27'd0, lsu_rd},       32'd5);
        check("add_rd_wen",    {31'd0, lsu_rd_wen},   32'd1);
        check("add_mem_rvld",  {31'd0, lsu_mem_rvld}, 32'd0);
        check("add_no_req",    {31'd0, mem_req},      32'd0);
        check("add_busy",      {31'd0, ex_rdy},       32'd0);
        @(negedge CLK);
        check("add_ready_off", {31'd0, lsu_ready},    32'd0);

        // SB 0x1003, grant withheld for 3 request cycles
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("sb_req_held", {31'd0, mem_req},   32'd1);
            check("sb_we",       {31'd0, mem_we},    32'd1);
            check("sb_addr",     mem_addr,           32'h0000_1000);
            check("sb_wstrb",    {28'd0, mem_wstrb}, 32'b1000);
            check("sb_wdata",    mem_wdata,          32'hABAB_ABAB);
            check("sb_no_ready", {31'd0, lsu_ready}, 32'd0);
            @(negedge CLK);
        end
        mem_gnt = 1'b1;
        check("sb_req_at_gnt", {31'd0, mem_req}, 32'd1);
        @(negedge CLK);
        mem_gnt = 1'b0;
        check("sb_ready",      {31'd0, lsu_ready},    32'd1);
        check("sb_rd_wen",     {31'd0, lsu_rd_wen},   32'd0);
        check("sb_mem_rvld",   {31'd0, lsu_mem_rvld}, 32'd0);
        check("sb_req_drop",   {31'd0, mem_req},      32'd0);
        @(negedge CLK);

        // LH signed 0x2002, two wait cycles before data
        issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'd0, 5'd9, 1'b1);
        check("lh_req",  {31'd0, mem_req}, 32'd1);
        check("lh_we",   {31'd0, mem_we},  32'd0);
        check("lh_addr", mem_addr,         32'h0000_2000);
        mem_gnt = 1'b1;
        @(negedge CLK);
        mem_gnt = 1'b0;
        check("lh_req_drop", {31'd0, mem_req}, 32'd0);
        repeat (2) begin
            check("lh_wait_no_ready", {31'd0, lsu_ready}, 32'd0);
            @(negedge CLK);
        end
        mem_rvld = 1'b1; mem_rdata = 32'h8001_5A5A;
        @(negedge CLK);
        mem_rvld = 1'b0; mem_rdata = 32'h0;
        check("lh_ready",    {31'd0, lsu_ready},    32'd1);
        check("lh_mem_rvld", {31'd0, lsu_mem_rvld}, 32'd1);
        check("lh_rdata",    lsu_mem_rdata,         32'h8001_5A5A);
        check("lh_rstrb",    {28'd0, lsu_rstrb},    32'b1100);
        check("lh_lsign",    {31'd0, lsu_lsign},    32'd1);
        check("lh_rd_wen",   {31'd0, lsu_rd_wen},   32'd1);
        check("lh_rd",       {27'd0, lsu_rd},       32'd9);
        @(negedge CLK);

        // LW 0x3000 with a spurious response while still requesting
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, 5'd3, 1'b1);
        mem_rvld = 1'b1; mem_rdata = 32'hDEAD_0000;
        @(negedge CLK);
        mem_rvld = 1'b0;
        check("lw_spur_no_ready", {31'd0, lsu_ready}, 32'd0);
        check("lw_spur_req",      {31'd0, mem_req},   32'd1);
        check("lw_spur_kept",     lsu_mem_rdata,      32'h8001_5A5A);
        mem_gnt = 1'b1;
        @(negedge CLK);
        mem_gnt = 1'b0;
        mem_rvld = 1'b1; mem_rdata = 32'hCAFE_BABE;
        @(negedge CLK);
        mem_rvld = 1'b0;
        check("lw_ready", {31'd0, lsu_ready}, 32'd1);
        check("lw_rdata", lsu_mem_rdata,      32'hCAFE_BABE);
        check("lw_rstrb", {28'd0, lsu_rstrb}, 32'b0000);
        @(negedge CLK);

        // Reset while waiting for load data, then a late response
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 5'd4, 1'b1);
        mem_gnt = 1'b1;
        @(negedge CLK);
        mem_gnt = 1'b0;
        RSTN = 1'b0;
        #1;
        check("rw_mem_req",   {31'd0, mem_req},      32'd0);
        check("rw_mem_addr",  mem_addr,              32'd0);
        check("rw_lsu_out",   lsu_out,               32'd0);
        check("rw_lsu_rd",    {27'd0, lsu_rd},       32'd0);
        check("rw_rd_wen",    {31'd0, lsu_rd_wen},   32'd0);
        check("rw_rdata",     lsu_mem_rdata,         32'd0);
        check("rw_out_vld",   {31'd0, lsu_out_vld},  32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        mem_rvld = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge CLK);
        mem_rvld = 1'b0;
        check("rw_late_no_ready", {31'd0, lsu_ready}, 32'd0);
        check("rw_late_rdata",    lsu_mem_rdata,      32'd0);
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0077, 32'd0, 5'd1, 1'b1);
        check("rw_next_ready", {31'd0, lsu_ready}, 32'd1);
        check("rw_next_out",   lsu_out,            32'h0000_0077);
        @(negedge CLK);

        // SW with reserved size 3 treated as word
        issue(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_6000, 32'h0102_0304, 5'd2, 1'b0);
        check("sw_wstrb", {28'd0, mem_wstrb}, 32'b1111);
        check("sw_wdata", mem_wdata,          32'h0102_0304);
        mem_gnt = 1'b1;
        @(negedge CLK);
        mem_gnt = 1'b0;
        check("sw_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge CLK);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned LW traps without touching memory
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'd0, 5'd6, 1'b1);
        check("mis_no_req",   {31'd0, mem_req},      32'd0);
        check("mis_ready",    {31'd0, lsu_ready},    32'd1);
        check("mis_flag",     {31'd0, lsu_misalign}, 32'd1);
        check("mis_rd_wen",   {31'd0, lsu_rd_wen},   32'd0);
        check("mis_mem_rvld", {31'd0, lsu_mem_rvld}, 32'd0);
        @(negedge CLK);
        check("mis_flag_off", {31'd0, lsu_misalign}, 32'd0);
`else
        // Misaligned LW proceeds at the aligned word address
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'd0, 5'd6, 1'b1);
        check("mis_req",  {31'd0, mem_req}, 32'd1);
        check("mis_addr", mem_addr,         32'h0000_4000);
        mem_gnt = 1'b1;
        @(negedge CLK);
        mem_gnt = 1'b0;
        mem_rvld = 1'b1; mem_rdata = 32'h1122_3344;
        @(negedge CLK);
        mem_rvld = 1'b0;
        check("mis_ready",    {31'd0, lsu_ready},    32'd1);
        check("mis_rdata",    lsu_mem_rdata,         32'h1122_3344);
        check("mis_flag",     {31'd0, lsu_misalign}, 32'd0);
        check("mis_mem_rvld", {31'd0, lsu_mem_rvld}, 32'd1);
        @(negedge CLK);

        // Odd-address SH uses the half lanes of addr[1]
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2003, 32'h1234_ABCD, 5'd0, 1'b0);
        check("sh_addr",  mem_addr,           32'h0000_2000);
        check("sh_wstrb", {28'd0, mem_wstrb}, 32'b1100);
        check("sh_wdata", mem_wdata,          32'hABCD_ABCD);
        mem_gnt = 1'b1;
        @(negedge CLK);
        mem_gnt = 1'b0;
        check("sh_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge CLK);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
